// File: rtl/uart_rx_if.sv
// Receive-side output bundle of uart_rx: the received word plus its status pulses.
// The receiver drives it (master); the downstream FIFO/register bank listens (slave).
`timescale 1ns/1ps
interface uart_rx_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] rx_data_out;
    logic                 rx_valid_out;
    logic                 rx_frame_err_out;
    logic                 rx_busy_out;

    modport master (
        output rx_data_out,
        output rx_valid_out,
        output rx_frame_err_out,
        output rx_busy_out
    );

    modport slave (
        input rx_data_out,
        input rx_valid_out,
        input rx_frame_err_out,
        input rx_busy_out
    );
endinterface

// File: rtl/uart_rx.sv
// UART receiver: 2-FF input synchroniser, start-bit qualification at half a bit,
// mid-bit data sampling on an oversampling tick, framing-error detection and break hold-off.
`timescale 1ns/1ps
module uart_rx #(
    parameter int OVERSAMPLING = 8,
    parameter int DATA_BITS    = 8
) (
    input  logic      sysclk_in,
    input  logic      rst_in,
    input  logic      baud_tick_in,
    input  logic      rx_serial_in,
    uart_rx_if.master rx_if
);
    localparam int CNT_W = $clog2(OVERSAMPLING);
    localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(OVERSAMPLING / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLING - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BREAK
    } state_t;

    logic                 r_sync_meta;
    logic                 r_sync;
    state_t               r_state;
    logic [CNT_W-1:0]     r_cnt;
    logic [IDX_W-1:0]     r_idx;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] r_data;
    logic                 r_valid;
    logic                 r_err;

    state_t               w_state_nxt;
    logic [CNT_W-1:0]     w_cnt_nxt;
    logic [IDX_W-1:0]     w_idx_nxt;
    logic [DATA_BITS-1:0] w_shift_nxt;
    logic [DATA_BITS-1:0] w_data_nxt;
    logic                 w_valid_nxt;
    logic                 w_err_nxt;
    logic                 w_busy;

    // Idle-high line, so both stages come out of reset at 1 to avoid a false start.
    always_ff @(posedge sysclk_in) begin
        if (rst_in) begin
            r_sync_meta <= 1'b1;
            r_sync      <= 1'b1;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge value; blocking here would collapse the two stages into one.
            r_sync_meta <= rx_serial_in;
            r_sync      <= r_sync_meta;
        end
    end

    always_ff @(posedge sysclk_in) begin
        if (rst_in) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shift <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
            r_shift <= w_shift_nxt;
            r_data  <= w_data_nxt;
            r_valid <= w_valid_nxt;
            r_err   <= w_err_nxt;
        end
    end

    always_comb begin
        // NOTE: every output gets a default before the case, so no path leaves one unassigned and no latch is inferred.
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        w_shift_nxt = r_shift;
        w_data_nxt  = r_data;
        w_valid_nxt = 1'b0;
        w_err_nxt   = 1'b0;

        if (baud_tick_in) begin
            unique case (r_state)
                ST_IDLE: begin
                    if (!r_sync) begin
                        w_state_nxt = ST_START;
                        w_cnt_nxt   = '0;
                    end
                end
                ST_START: begin
                    if (r_cnt == CNT_HALF) begin
                        w_cnt_nxt = '0;
                        if (!r_sync) begin
                            w_state_nxt = ST_DATA;
                            w_idx_nxt   = '0;
                        end else begin
                            w_state_nxt = ST_IDLE;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
                ST_DATA: begin
                    if (r_cnt == CNT_LAST) begin
                        w_shift_nxt[r_idx] = r_sync;
                        w_cnt_nxt          = '0;
                        if (r_idx == IDX_LAST) begin
                            w_state_nxt = ST_STOP;
                        end else begin
                            w_idx_nxt = r_idx + IDX_W'(1);
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
                ST_STOP: begin
                    // Leaving at mid-stop lets a start bit right after the stop bit be caught.
                    if (r_cnt == CNT_LAST) begin
                        w_cnt_nxt = '0;
                        if (r_sync) begin
                            w_data_nxt  = r_shift;
                            w_valid_nxt = 1'b1;
                            w_state_nxt = ST_IDLE;
                        end else begin
                            w_err_nxt   = 1'b1;
                            w_state_nxt = ST_BREAK;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
                ST_BREAK: begin
                    if (r_sync) begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    assign w_busy = (r_state != ST_IDLE);

    assign rx_if.rx_data_out      = r_data;
    assign rx_if.rx_valid_out     = r_valid;
    assign rx_if.rx_frame_err_out = r_err;
    assign rx_if.rx_busy_out      = w_busy;
endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: table of frames, hand-written corner sequences
// (glitch, break, reset, tick stall) and random frames against a frame-level model.
`timescale 1ns/1ps
module tb_uart_rx;
    localparam int OS      = 8;
    localparam int DB      = 8;
    localparam int TICK_P  = 4;
    localparam int BIT_P   = OS * TICK_P;

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         gap;
        logic       exp_err;
        logic [7:0] exp_data;
    } vec_t;

    typedef struct {
        logic       is_err;
        logic [7:0] data;
    } ev_t;

    logic clk;
    logic rst_in;
    logic baud_tick_in;
    logic rx_serial_in;
    logic tick_en;
    int   tick_ph;
    logic prev_valid;

    int   n_vec;
    int   n_err;
    ev_t  ev_q[$];
    logic [7:0] last_good;
    vec_t vecs[6];

    uart_rx_if #(.DATA_BITS(DB)) rx_if ();

    uart_rx #(
        .OVERSAMPLING (OS),
        .DATA_BITS    (DB)
    ) dut (
        .sysclk_in    (clk),
        .rst_in       (rst_in),
        .baud_tick_in (baud_tick_in),
        .rx_serial_in (rx_serial_in),
        .rx_if        (rx_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        baud_tick_in = 1'b0;
        tick_ph      = 0;
        forever begin
            @(negedge clk);
            baud_tick_in = tick_en && (tick_ph == 0);
            tick_ph      = (tick_ph + 1) % TICK_P;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Records every output pulse so frames can be checked after the fact.
    initial begin
        prev_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (rx_if.rx_valid_out || rx_if.rx_frame_err_out) begin
                check("valid_err_exclusive", 32'(rx_if.rx_valid_out & rx_if.rx_frame_err_out), 0);
                if (rx_if.rx_valid_out) begin
                    check("valid_one_cycle", 32'(prev_valid), 0);
                    ev_q.push_back('{1'b0, rx_if.rx_data_out});
                end
                if (rx_if.rx_frame_err_out) begin
                    ev_q.push_back('{1'b1, rx_if.rx_data_out});
                end
            end
            prev_valid = rx_if.rx_valid_out;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic freeze_ticks();
        tick_en = 1'b0;
        wait_clk(100);
        check("freeze_busy", 32'(rx_if.rx_busy_out), 1);
        check("freeze_data", 32'(rx_if.rx_data_out), 32'(last_good));
        check("freeze_no_pulse", ev_q.size(), 0);
        tick_en = 1'b1;
    endtask

    // Drives one frame; the line is held through a tick stall so bit timing stays intact.
    task automatic send_frame(input logic [7:0] d, input logic stop, input int freeze_bit);
        rx_serial_in = 1'b0;
        wait_clk(12);
        check("busy_in_start", 32'(rx_if.rx_busy_out), 1);
        wait_clk(BIT_P - 12);
        for (int i = 0; i < DB; i++) begin
            rx_serial_in = d[i];
            if (i == freeze_bit) begin
                wait_clk(10);
                freeze_ticks();
                wait_clk(BIT_P - 10);
            end else begin
                wait_clk(BIT_P);
            end
        end
        rx_serial_in = stop;
        wait_clk(BIT_P);
    endtask

    // Frame-level model: good stop bit delivers the word, bad one reports the held word.
    task automatic expect_frame(input logic [7:0] d, input logic stop);
        ev_t ev;
        check("event_count", ev_q.size(), 1);
        if (ev_q.size() > 0) begin
            ev = ev_q.pop_front();
            check("event_is_err", 32'(ev.is_err), 32'(!stop));
            check("event_data", 32'(ev.data), stop ? 32'(d) : 32'(last_good));
        end
        if (stop) last_good = d;
        check("data_hold", 32'(rx_if.rx_data_out), 32'(last_good));
    endtask

    task automatic idle_gap(input int bits);
        rx_serial_in = 1'b1;
        wait_clk(bits * BIT_P);
    endtask

    initial begin
        n_vec        = 0;
        n_err        = 0;
        last_good    = 8'h00;
        tick_en      = 1'b1;
        rst_in       = 1'b1;
        rx_serial_in = 1'b1;

        vecs[0] = '{8'hA5, 1'b1, 1, 1'b0, 8'hA5};
        vecs[1] = '{8'h00, 1'b1, 0, 1'b0, 8'h00};
        vecs[2] = '{8'hFF, 1'b1, 0, 1'b0, 8'hFF};
        vecs[3] = '{8'h3C, 1'b1, 2, 1'b0, 8'h3C};
        vecs[4] = '{8'h5A, 1'b0, 1, 1'b1, 8'h3C};
        vecs[5] = '{8'hC3, 1'b1, 1, 1'b0, 8'hC3};

        wait_clk(4);
        rst_in = 1'b0;
        wait_clk(2);
        check("reset_data", 32'(rx_if.rx_data_out), 0);
        check("reset_valid", 32'(rx_if.rx_valid_out), 0);
        check("reset_err", 32'(rx_if.rx_frame_err_out), 0);
        check("reset_busy", 32'(rx_if.rx_busy_out), 0);
        idle_gap(1);

        // Table: single frame, back-to-back frames, framing error keeping prior data.
        for (int v = 0; v < 6; v++) begin
            send_frame(vecs[v].data, vecs[v].stop, -1);
            check("busy_after_stop", 32'(rx_if.rx_busy_out), 32'(vecs[v].exp_err));
            check("table_expect_err", 32'(ev_q.size() > 0 ? ev_q[0].is_err : 1'bx), 32'(vecs[v].exp_err));
            check("table_expect_data", 32'(ev_q.size() > 0 ? ev_q[0].data : 8'hxx), 32'(vecs[v].exp_data));
            expect_frame(vecs[v].data, vecs[v].stop);
            idle_gap(vecs[v].gap);
        end

        // Short low glitch: rejected at the half-bit start check.
        rx_serial_in = 1'b0;
        wait_clk(2 * TICK_P);
        rx_serial_in = 1'b1;
        wait_clk(4);
        check("glitch_busy_seen", 32'(rx_if.rx_busy_out), 1);
        wait_clk(40);
        check("glitch_back_idle", 32'(rx_if.rx_busy_out), 0);
        check("glitch_no_pulse", ev_q.size(), 0);
        check("glitch_data", 32'(rx_if.rx_data_out), 32'(last_good));
        idle_gap(1);

        // Break: bad stop, line held low three more bits, then a good frame.
        send_frame(8'h55, 1'b0, -1);
        expect_frame(8'h55, 1'b0);
        wait_clk(3 * BIT_P);
        check("break_busy", 32'(rx_if.rx_busy_out), 1);
        check("break_no_retrigger", ev_q.size(), 0);
        idle_gap(1);
        check("break_released", 32'(rx_if.rx_busy_out), 0);
        send_frame(8'h81, 1'b1, -1);
        expect_frame(8'h81, 1'b1);
        idle_gap(1);

        // Reset during data bit 4 of 0xC3; the transmitter aborts with it.
        rx_serial_in = 1'b0;
        wait_clk(BIT_P);
        for (int i = 0; i < 4; i++) begin
            rx_serial_in = (8'hC3 >> i) & 8'h01 ? 1'b1 : 1'b0;
            wait_clk(BIT_P);
        end
        rx_serial_in = 1'b0;
        wait_clk(BIT_P / 2);
        rst_in       = 1'b1;
        rx_serial_in = 1'b1;
        wait_clk(1);
        rst_in = 1'b0;
        check("midreset_data", 32'(rx_if.rx_data_out), 0);
        check("midreset_valid", 32'(rx_if.rx_valid_out), 0);
        check("midreset_err", 32'(rx_if.rx_frame_err_out), 0);
        check("midreset_busy", 32'(rx_if.rx_busy_out), 0);
        last_good = 8'h00;
        idle_gap(2);
        check("midreset_no_pulse", ev_q.size(), 0);
        send_frame(8'h5A, 1'b1, -1);
        expect_frame(8'h5A, 1'b1);
        idle_gap(1);

        // Tick stall of 100 cycles inside data bit 3.
        send_frame(8'h96, 1'b1, 3);
        expect_frame(8'h96, 1'b1);
        idle_gap(1);

        // Random frames, some with a bad stop bit.
        for (int r = 0; r < 12; r++) begin
            logic [7:0] d;
            logic       s;
            d = 8'($urandom);
            s = ($urandom_range(3) != 0);
            send_frame(d, s, -1);
            expect_frame(d, s);
            idle_gap(s ? int'($urandom_range(1)) : 1 + int'($urandom_range(1)));
        end

        idle_gap(2);
        check("final_no_stray_pulse", ev_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
